// File: rtl/control_unit_if.sv
// Bundles the ROM fetch port and every DataPath control line driven by control_unit.
// The control unit uses the master modport; the ROM/DataPath side uses the slave modport.
interface control_unit_if #(
  parameter int I_ADDR_W = 7,
  parameter int D_ADDR_W = 8,
  parameter int R_ADDR_W = 4
);
  logic [15:0]         I_data;
  logic [I_ADDR_W-1:0] I_addr;
  logic [D_ADDR_W-1:0] D_addr;
  logic [R_ADDR_W-1:0] RF_W_addr;
  logic [R_ADDR_W-1:0] RF_A_addr;
  logic [R_ADDR_W-1:0] RF_B_addr;
  logic                D_wr;
  logic                RF_s;
  logic                RF_W_en;
  logic [3:0]          ALU_sel;
  logic                halted;
  logic [2:0]          state_dbg;

  modport master (
    input  I_data,
    output I_addr, D_addr, RF_W_addr, RF_A_addr, RF_B_addr,
    output D_wr, RF_s, RF_W_en, ALU_sel, halted, state_dbg
  );

  modport slave (
    output I_data,
    input  I_addr, D_addr, RF_W_addr, RF_A_addr, RF_B_addr,
    input  D_wr, RF_s, RF_W_en, ALU_sel, halted, state_dbg
  );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute controller in front of DataPath; one instruction at a time.
// Optional CU_SINGLE_STEP_EN adds a step input that gates the FETCH -> DECODE advance.
//
// state   | meaning
// INIT    | one cycle after reset release
// FETCH   | present PC to ROM, bump PC
// DECODE  | capture ROM word into IR, branch on opcode
// LOAD_A  | memory read address set up, RF mux on memory
// LOAD_B  | same, with register write strobe
// STORE   | data memory write strobe
// ALU     | register write from ALU result
// HALT    | frozen until reset
module control_unit #(
  parameter int I_ADDR_W = 7,
  parameter int D_ADDR_W = 8,
  parameter int R_ADDR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  control_unit_if.master   bus
`ifdef CU_SINGLE_STEP_EN
  , input logic            step
`endif
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_LOAD_A = 3'd3,
    S_LOAD_B = 3'd4,
    S_STORE  = 3'd5,
    S_ALU    = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  state_t              state_q, state_d;
  logic [I_ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]         ir_q, ir_d;
  logic                advance;

  logic [3:0]          op;
  logic [R_ADDR_W-1:0] f1, f2, f3;

  assign op = ir_q[15:12];
  assign f1 = ir_q[11:8];
  assign f2 = ir_q[7:4];
  assign f3 = ir_q[3:0];

`ifdef CU_SINGLE_STEP_EN
  assign advance = step;
`else
  assign advance = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Outputs depend only on state and IR; I_data feeds only the next-state/IR path.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    bus.D_addr    = ir_q[D_ADDR_W-1:0];
    bus.RF_W_addr = f1;
    bus.RF_A_addr = f1;
    bus.RF_B_addr = f3;
    bus.D_wr      = 1'b0;
    bus.RF_s      = 1'b0;
    bus.RF_W_en   = 1'b0;
    bus.ALU_sel   = '0;
    bus.halted    = 1'b0;

    unique case (state_q)
      S_INIT: state_d = S_FETCH;
      S_FETCH: begin
        if (advance) begin
          pc_d    = pc_q + 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ir_d = bus.I_data;
        unique case (bus.I_data[15:12])
          4'b0000: state_d = S_FETCH;
          4'b0001: state_d = S_STORE;
          4'b0010: state_d = S_LOAD_A;
          4'b0011: state_d = S_HALT;
          default: state_d = S_ALU;
        endcase
      end
      S_LOAD_A: begin
        bus.RF_s = 1'b1;
        state_d  = S_LOAD_B;
      end
      S_LOAD_B: begin
        bus.RF_s    = 1'b1;
        bus.RF_W_en = 1'b1;
        state_d     = S_FETCH;
      end
      S_STORE: begin
        bus.D_wr = 1'b1;
        state_d  = S_FETCH;
      end
      S_ALU: begin
        bus.RF_A_addr = f2;
        bus.ALU_sel   = op - 4'd4;
        bus.RF_W_en   = 1'b1;
        state_d       = S_FETCH;
      end
      S_HALT: bus.halted = 1'b1;
      default: state_d = S_INIT;
    endcase
  end

  assign bus.I_addr    = pc_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a CPI-level program model predicts each strobe event
// (cycle, fields, PC); a negedge monitor pops and compares whenever the DUT strobes or halts.
module tb_control_unit;
  localparam int IW = 7;
  localparam logic [2:0] K_ST = 3'd1, K_LD = 3'd2, K_ALU = 3'd3, K_HALT = 3'd4;

  typedef struct packed {
    int         cyc;
    logic [2:0] kind;
    logic [7:0] d_addr;
    logic [3:0] w;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sel;
    logic [6:0] ipc;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef CU_SINGLE_STEP_EN
  logic step = 1'b1;
`endif

  control_unit_if #(.I_ADDR_W(IW), .D_ADDR_W(8), .R_ADDR_W(4)) bus();

  control_unit #(.I_ADDR_W(IW), .D_ADDR_W(8), .R_ADDR_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef CU_SINGLE_STEP_EN
    , .step(step)
`endif
  );

  logic [15:0] rom [128];
  always @(posedge clk) bus.I_data <= rom[bus.I_addr];

  int cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  int  n_vec = 0;
  int  n_err = 0;
  bit  mon_en = 1'b0;
  ev_t exp_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ev_t mask(input ev_t e);
    ev_t m = e;
    case (e.kind)
      K_ST:   begin m.w = '0; m.b = '0; m.sel = '0; end
      K_LD:   begin m.a = '0; m.b = '0; m.sel = '0; end
      K_ALU:  m.d_addr = '0;
      default: begin m.d_addr = '0; m.w = '0; m.a = '0; m.b = '0; m.sel = '0; end
    endcase
    return m;
  endfunction

  // Reference: walk the program with per-opcode cycle costs measured from the first FETCH (cycle 1).
  task automatic build_expect(output int halt_t);
    int pc = 0;
    int t = 1;
    ev_t e;
    halt_t = 0;
    for (int n = 0; n < 2000; n++) begin
      logic [15:0] ins;
      int op, pcn;
      ins = rom[pc];
      op  = int'(ins[15:12]);
      pcn = (pc + 1) % 128;
      e = '0;
      e.d_addr = ins[7:0];
      e.ipc    = 7'(pcn);
      if (op == 0) begin
        t += 2;
      end else if (op == 1) begin
        e.cyc = t + 2; e.kind = K_ST; e.a = ins[11:8];
        exp_q.push_back(e); t += 3;
      end else if (op == 2) begin
        e.cyc = t + 3; e.kind = K_LD; e.w = ins[11:8];
        exp_q.push_back(e); t += 4;
      end else if (op == 3) begin
        e.cyc = t + 2; e.kind = K_HALT;
        exp_q.push_back(e); halt_t = t + 2;
        break;
      end else begin
        e.cyc = t + 2; e.kind = K_ALU; e.w = ins[11:8]; e.a = ins[7:4]; e.b = ins[3:0];
        e.sel = 4'(op - 4);
        exp_q.push_back(e); t += 3;
      end
      pc = pcn;
    end
  endtask

  logic       prev_halted = 1'b0;
  logic       prev_rfs, prev_wen;
  logic [7:0] prev_daddr;
  logic [3:0] prev_waddr;
  logic [6:0] halt_pc;

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (bus.halted) begin
        chk("halt_dwr", bus.D_wr, 0);
        chk("halt_wen", bus.RF_W_en, 0);
      end
      if (bus.halted && prev_halted) begin
        chk("halt_pc_frozen", bus.I_addr, halt_pc);
      end else if (bus.D_wr || bus.RF_W_en || bus.halted) begin
        ev_t o, e;
        o = '0;
        o.cyc = cyc; o.d_addr = bus.D_addr; o.w = bus.RF_W_addr;
        o.a = bus.RF_A_addr; o.b = bus.RF_B_addr; o.sel = bus.ALU_sel; o.ipc = bus.I_addr;
        o.kind = bus.halted ? K_HALT : bus.D_wr ? K_ST : bus.RF_s ? K_LD : K_ALU;
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_event: got %0h expected none", o);
        end else begin
          e = exp_q.pop_front();
          chk("event", mask(o), mask(e));
          if (e.kind == K_LD)
            chk("load_a_phase", {prev_rfs, prev_wen, prev_daddr, prev_waddr},
                {1'b1, 1'b0, e.d_addr, e.w});
          if (e.kind == K_HALT) halt_pc = e.ipc;
        end
      end
      prev_halted = bus.halted;
      prev_rfs    = bus.RF_s;
      prev_wen    = bus.RF_W_en;
      prev_daddr  = bus.D_addr;
      prev_waddr  = bus.RF_W_addr;
    end else begin
      prev_halted = 1'b0;
    end
  end

  task automatic restart();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_program(input int hold);
    int halt_t;
    mon_en = 1'b0;
    exp_q.delete();
    build_expect(halt_t);
    restart();
    mon_en = 1'b1;
    while (!bus.halted && cyc < halt_t + 20) @(negedge clk);
    repeat (hold) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("halted_reached", bus.halted, 1);
    mon_en = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
  endtask

  initial begin
    clear_rom();
    rom[0] = 16'h1712; rom[1] = 16'h3000;
    restart();
    chk("reset_state", bus.state_dbg, 0);
    chk("reset_daddr", bus.D_addr, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.D_wr) break;
    end
    chk("store_seen", bus.D_wr, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_dwr_drop", bus.D_wr, 0);
    chk("rst_state", bus.state_dbg, 0);
    chk("rst_pc", bus.I_addr, 0);
    chk("rst_halted", bus.halted, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_state", bus.state_dbg, 1);
    chk("post_rst_pc", bus.I_addr, 0);
    @(posedge clk); #1;
    chk("decode_state", bus.state_dbg, 2);
    chk("decode_pc", bus.I_addr, 1);

    clear_rom(); rom[0] = 16'h2305; rom[1] = 16'h3000; run_program(10);
    clear_rom(); rom[0] = 16'h1712; rom[1] = 16'h3000; run_program(10);
    clear_rom(); rom[0] = 16'h5123; rom[1] = 16'h3000; run_program(10);
    clear_rom(); rom[5] = 16'h3000; run_program(100);
    chk("halt_pc6", bus.I_addr, 6);

    clear_rom();
    restart();
    @(negedge clk);
    for (int k = 0; k < 130; k++) begin
      chk("wrap_pc", bus.I_addr, k % 128);
      repeat (2) @(negedge clk);
    end

    for (int p = 0; p < 25; p++) begin
      int len;
      for (int i = 0; i < 128; i++) rom[i] = 16'($urandom());
      len = $urandom_range(5, 40);
      for (int i = 0; i < len; i++) begin
        logic [3:0] op;
        logic [11:0] r;
        do op = 4'($urandom()); while (op == 4'd3);
        r = 12'($urandom());
        rom[i] = {op, r};
      end
      rom[len] = 16'h3000;
      run_program(10);
    end

`ifdef CU_SINGLE_STEP_EN
    clear_rom();
    step = 1'b0;
    restart();
    repeat (6) @(negedge clk);
    chk("step_hold_pc", bus.I_addr, 0);
    chk("step_hold_state", bus.state_dbg, 1);
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (4) @(negedge clk);
    end
    chk("step_pc3", bus.I_addr, 3);
    step = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
